// File: rtl/riscy_pkg.sv
// Shared definitions for the RISCY ALU issue controller: opcodes, FSM states,
// instruction field positions and opcode classification.
package riscy_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int RF_AW   = 2;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] LDI       = 4'b0001;
  localparam logic [OPC_W-1:0] A_PLUS_B  = 4'b0010;
  localparam logic [OPC_W-1:0] A_MINUS_B = 4'b0011;
  localparam logic [OPC_W-1:0] A_AND_B   = 4'b0100;
  localparam logic [OPC_W-1:0] A_OR_B    = 4'b0101;
  localparam logic [OPC_W-1:0] A_XOR_B   = 4'b0110;
  localparam logic [OPC_W-1:0] NOT_A     = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic cf;
    logic of;
    logic sf;
    logic zf;
  } flags_t;

  typedef struct packed {
    logic legal;
    logic alu;
  } op_class_t;

  function automatic op_class_t decode_op(input logic [OPC_W-1:0] op);
    op_class_t c;
    c.alu   = (op >= A_PLUS_B) && (op <= NOT_A);
    c.legal = c.alu || (op == LDI);
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREGS x WIDTH register file: two combinational read ports, one synchronous
// write port, asynchronously cleared on rst.
module alu_ctrl_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: the array is reset because software relies on registers reading 0
  // after reset; this forces flops instead of a RAM macro, fine at 4 entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the RISCY ALU, one instruction in flight.
// Optional flag capture: define ALU_CTRL_FLAGS_EN to present ALU flags on RES_*F.
module alu_issue_ctrl
  import riscy_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [OPC_W-1:0]   ALU_OPCODE,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  output logic               ALU_EN,
  output logic               ALU_OE,
  input  logic [WIDTH-1:0]   ALU_OUT,
  input  logic               ALU_CF,
  input  logic               ALU_OF,
  input  logic               ALU_SF,
  input  logic               ALU_ZF,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [WIDTH-1:0]   RES_DATA,
  output logic               RES_CF,
  output logic               RES_OF,
  output logic               RES_SF,
  output logic               RES_ZF,
  output logic               RES_ERR
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  logic [WIDTH-1:0] rs1_data, rs2_data;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  op_class_t        cls_in, cls_q;
  logic             alu_drive;

  assign cls_in = decode_op(INSTR[OPC_MSB:OPC_LSB]);
  assign cls_q  = decode_op(op_q);

  alu_ctrl_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (RF_AW)
  ) u_regfile (
    .clk     (CLK),
    .rst     (RST),
    .raddr_a (INSTR[RS1_MSB:RS1_LSB]),
    .raddr_b (INSTR[RS2_MSB:RS2_LSB]),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .we      (wr_en),
    .waddr   (rd_q),
    .wdata   (wr_data)
  );

  assign wr_data = cls_q.alu ? ALU_OUT : imm_q;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (INSTR_VALID) begin
          op_d    = INSTR[OPC_MSB:OPC_LSB];
          rd_d    = INSTR[RD_MSB:RD_LSB];
          a_d     = rs1_data;
          b_d     = rs2_data;
          imm_d   = WIDTH'(INSTR[IMM_MSB:IMM_LSB]);
          state_d = cls_in.alu ? ISSUE : WB;
        end
      end
      ISSUE: state_d = WB;
      WB: begin
        wr_en      = cls_q.legal;
        res_data_d = cls_q.legal ? wr_data : '0;
        res_err_d  = ~cls_q.legal;
        state_d    = DONE;
      end
      DONE: if (RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // LDI and illegal opcodes never touch the ALU, so its port stays quiet.
  assign alu_drive   = ((state_q == ISSUE) || (state_q == WB)) && cls_q.alu;
  assign ALU_EN      = alu_drive;
  assign ALU_OE      = alu_drive && (state_q == WB);
  assign ALU_OPCODE  = alu_drive ? op_q : '0;
  assign ALU_A       = alu_drive ? a_q  : '0;
  assign ALU_B       = alu_drive ? b_q  : '0;

  assign INSTR_READY = (state_q == IDLE);
  assign RES_VALID   = (state_q == DONE);
  assign RES_DATA    = res_data_q;
  assign RES_ERR     = res_err_q;

`ifdef ALU_CTRL_FLAGS_EN
  flags_t res_fl_q, res_fl_d;

  always_comb begin
    res_fl_d = res_fl_q;
    if (state_q == WB) begin
      if (cls_q.alu)        res_fl_d = '{cf: ALU_CF, of: ALU_OF, sf: ALU_SF, zf: ALU_ZF};
      else if (cls_q.legal) res_fl_d = '{cf: 1'b0, of: 1'b0, sf: 1'b0, zf: (imm_q == '0)};
      else                  res_fl_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) res_fl_q <= '0;
    else     res_fl_q <= res_fl_d;
  end

  assign RES_CF = res_fl_q.cf;
  assign RES_OF = res_fl_q.of;
  assign RES_SF = res_fl_q.sf;
  assign RES_ZF = res_fl_q.zf;
`else
  assign RES_CF = 1'b0;
  assign RES_OF = 1'b0;
  assign RES_SF = 1'b0;
  assign RES_ZF = 1'b0;
`endif

endmodule
